squareroot_piped_v3: RTL and testbench

SQUAREROOT_PIPED_V3 -- requirements
Module: squareroot_piped_v3

---
 rtl/squareroot_piped_v3.sv | 126 ++++++++++++
 tb/tb_squareroot_piped_v3.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/squareroot_piped_v3.sv
// Pipelined digit-by-digit fixed-point square root with valid/ready and tag sideband.
// Optional neg_err output when SQRT_NEG_ERR_EN is defined.
module squareroot_piped_v3 #(
    parameter int BITSIZE = 16,
    parameter int FRAC    = 11,
    parameter int BPS     = 4,
    parameter int TAGW    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BITSIZE-1:0] data_in,
    input  logic [TAGW-1:0]    tag_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BITSIZE-1:0] data_out,
    output logic [TAGW-1:0]    tag_out
`ifdef SQRT_NEG_ERR_EN
    ,
    output logic               neg_err
`endif
);

    localparam int IW     = BITSIZE - 1 + FRAC;
    localparam int RW     = (IW + 1) / 2;
    localparam int NSTAGE = (RW + BPS - 1) / BPS;
    localparam int RADW   = 2 * RW;
    localparam int REMW   = RW + 2;

    logic            v_q    [0:NSTAGE];
    logic [RADW-1:0] rad_q  [0:NSTAGE];
    logic [REMW-1:0] rem_q  [0:NSTAGE];
    logic [RW-1:0]   root_q [0:NSTAGE];
    logic [TAGW-1:0] tag_q  [0:NSTAGE];
    logic            neg_q  [0:NSTAGE];

    logic [RADW-1:0] rad_d  [1:NSTAGE];
    logic [REMW-1:0] rem_d  [1:NSTAGE];
    logic [RW-1:0]   root_d [1:NSTAGE];

    logic [RADW-1:0] rad_in;
    logic [RADW-1:0] rad_t;
    logic [REMW-1:0] rem_t;
    logic [REMW-1:0] trial_t;
    logic [RW-1:0]   root_t;
    logic            stall;
    logic            unused_ok;

    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = v_q[NSTAGE];
    assign data_out  = BITSIZE'(root_q[NSTAGE]);
    assign tag_out   = tag_q[NSTAGE];

    // Negative operands enter as a zero radicand, so their root is zero.
    always_comb begin
        rad_in = '0;
        if (!data_in[BITSIZE-1]) begin
            rad_in = RADW'(data_in[BITSIZE-2:0]) << FRAC;
        end
    end

    always_comb begin
        rad_t   = '0;
        rem_t   = '0;
        trial_t = '0;
        root_t  = '0;
        for (int s = 1; s <= NSTAGE; s++) begin
            rem_t  = rem_q[s-1];
            root_t = root_q[s-1];
            rad_t  = rad_q[s-1];
            for (int j = 0; j < BPS; j++) begin
                if ((s - 1) * BPS + j < RW) begin
                    rem_t   = {rem_t[REMW-3:0], rad_t[RADW-1 -: 2]};
                    rad_t   = rad_t << 2;
                    trial_t = {root_t, 2'b01};
                    if (rem_t >= trial_t) begin
                        rem_t  = rem_t - trial_t;
                        root_t = {root_t[RW-2:0], 1'b1};
                    end else begin
                        root_t = {root_t[RW-2:0], 1'b0};
                    end
                end
            end
            rem_d[s]  = rem_t;
            root_d[s] = root_t;
            rad_d[s]  = rad_t;
        end
    end

    // Slot 0 root/remainder stay at their cleared value: the empty partial root.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s <= NSTAGE; s++) begin
                v_q[s]    <= 1'b0;
                rad_q[s]  <= '0;
                rem_q[s]  <= '0;
                root_q[s] <= '0;
                tag_q[s]  <= '0;
                neg_q[s]  <= 1'b0;
            end
        end else if (!stall) begin
            v_q[0]   <= in_valid;
            rad_q[0] <= rad_in;
            tag_q[0] <= tag_in;
            neg_q[0] <= data_in[BITSIZE-1];
            for (int s = 1; s <= NSTAGE; s++) begin
                v_q[s]    <= v_q[s-1];
                rad_q[s]  <= rad_d[s];
                rem_q[s]  <= rem_d[s];
                root_q[s] <= root_d[s];
                tag_q[s]  <= tag_q[s-1];
                neg_q[s]  <= neg_q[s-1];
            end
        end
    end

`ifdef SQRT_NEG_ERR_EN
    assign neg_err   = neg_q[NSTAGE];
    assign unused_ok = ^{rem_q[NSTAGE], rad_q[NSTAGE]};
`else
    assign unused_ok = ^{rem_q[NSTAGE], rad_q[NSTAGE], neg_q[NSTAGE]};
`endif

endmodule

// File: tb/tb_squareroot_piped_v3.sv
// Scoreboard bench for squareroot_piped_v3: default build and a 24-bit BPS=1 build.
// Set SQRT_NEG_ERR_EN to also check the neg_err sideband.
module tb_squareroot_piped_v3;

    localparam int W  = 16;
    localparam int T  = 8;
    localparam int NA = 4;
    localparam int W2 = 24;
    localparam int T2 = 4;
    localparam int NB = 20;

    typedef struct {
        logic [W-1:0] d;
        logic [T-1:0] t;
        logic         n;
        int           acc;
        bit           lat;
    } exp_a_t;

    typedef struct {
        logic [W2-1:0] d;
        logic [T2-1:0] t;
        logic          n;
        int            acc;
    } exp_b_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  data_in, data_out;
    logic [T-1:0]  tag_in, tag_out;
    logic          iv_b, ir_b, ov_b, or_b;
    logic [W2-1:0] di_b, do_b;
    logic [T2-1:0] ti_b, to_b;
`ifdef SQRT_NEG_ERR_EN
    logic          neg_err, ne_b;
`endif

    squareroot_piped_v3 #(.BITSIZE(W), .FRAC(11), .BPS(4), .TAGW(T)) dut_a (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .tag_out(tag_out)
`ifdef SQRT_NEG_ERR_EN
        , .neg_err(neg_err)
`endif
    );

    squareroot_piped_v3 #(.BITSIZE(W2), .FRAC(16), .BPS(1), .TAGW(T2)) dut_b (
        .clk(clk), .reset(reset),
        .in_valid(iv_b), .in_ready(ir_b),
        .data_in(di_b), .tag_in(ti_b),
        .out_valid(ov_b), .out_ready(or_b),
        .data_out(do_b), .tag_out(to_b)
`ifdef SQRT_NEG_ERR_EN
        , .neg_err(ne_b)
`endif
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit rnd_mode = 0;
    exp_a_t q_a[$];
    exp_b_t q_b[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic longint isqrt(input longint v);
        longint lo = 0;
        longint hi = longint'(1) << 21;
        longint mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= v) lo = mid;
            else hi = mid;
        end
        return lo;
    endfunction

    always @(negedge clk) begin
        if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
        else out_ready = 1'b1;
    end

    task automatic send_a(input logic [W-1:0] d, input logic [T-1:0] t,
                          input logic [W-1:0] e, input logic n, input bit lat);
        int g = 0;
        @(negedge clk);
        in_valid = 1'b1; data_in = d; tag_in = t;
        #1;
        while (!in_ready && g < 200) begin
            @(negedge clk); #1; g++;
        end
        if (!in_ready) chk("send_a_timeout", 0, 1);
        else q_a.push_back('{e, t, n, cyc + 1, lat});
    endtask

    task automatic idle_a(input int k);
        repeat (k) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic send_b(input logic [W2-1:0] d, input logic [T2-1:0] t);
        logic [W2-1:0] e;
        e = d[W2-1] ? '0 : W2'(isqrt(longint'(d) << 16));
        @(negedge clk);
        iv_b = 1'b1; di_b = d; ti_b = t;
        #1;
        if (!ir_b) chk("send_b_ready", 0, 1);
        else q_b.push_back('{e, t, d[W2-1], cyc + 1});
    endtask

    task automatic drain(input int bound);
        int g = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && g < bound) begin
            @(negedge clk); g++;
        end
        chk("drain_a", q_a.size(), 0);
        chk("drain_b", q_b.size(), 0);
    endtask

    // Monitor A: pops on each accepted output, checks stall hold and in_ready.
    bit           stl_q = 0;
    logic [W-1:0] hd;
    logic [T-1:0] ht;
    always @(negedge clk) begin
        #2;
        if (reset) begin
            stl_q = 0;
        end else begin
            exp_a_t e;
            chk("in_ready", in_ready, !(out_valid && !out_ready));
            if (stl_q) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", data_out, hd);
                chk("stall_tag", tag_out, ht);
            end
            if (out_valid && out_ready) begin
                if (q_a.size() == 0) begin
                    chk("unexpected_out_a", out_valid, 0);
                end else begin
                    e = q_a.pop_front();
                    chk("data_a", data_out, e.d);
                    chk("tag_a", tag_out, e.t);
`ifdef SQRT_NEG_ERR_EN
                    chk("neg_err_a", neg_err, e.n);
`endif
                    if (e.lat) chk("latency_a", cyc - e.acc, NA);
                end
            end
            stl_q = out_valid && !out_ready;
            hd = data_out;
            ht = tag_out;
        end
    end

    always @(negedge clk) begin
        #2;
        if (!reset && ov_b) begin
            exp_b_t e;
            if (q_b.size() == 0) begin
                chk("unexpected_out_b", ov_b, 0);
            end else begin
                e = q_b.pop_front();
                chk("data_b", do_b, e.d);
                chk("tag_b", to_b, e.t);
`ifdef SQRT_NEG_ERR_EN
                chk("neg_err_b", ne_b, e.n);
`endif
                chk("latency_b", cyc - e.acc, NB);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [W2-1:0] vb [9];

    initial begin
        reset = 1'b1; in_valid = 1'b0; data_in = '0; tag_in = '0;
        iv_b = 1'b0; di_b = '0; ti_b = '0; or_b = 1'b1; out_ready = 1'b1;
        #8;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_tag_out", tag_out, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid_b", ov_b, 0);
        #4 reset = 1'b0;

        send_a(16'h0800, 8'd1, 16'h0800, 0, 1);
        send_a(16'h2000, 8'd2, 16'h1000, 0, 1);
        send_a(16'h0400, 8'd3, 16'h05A8, 0, 1);
        idle_a(3);
        send_a(16'h0000, 8'd4, 16'h0000, 0, 1);
        send_a(16'h000E, 8'd5, 16'h00A9, 0, 1);
        send_a(16'h3800, 8'd6, 16'h152A, 0, 1);
        send_a(16'h7FFF, 8'd7, 16'h1FFF, 0, 1);
        send_a(16'h800E, 8'd8, 16'h0000, 1, 1);
        send_a(16'h880E, 8'd9, 16'h0000, 1, 1);
        idle_a(1);
        drain(50);

        // data_in = 2*j^2 gives data_in*2^11 = (64*j)^2 exactly.
        rnd_mode = 1;
        for (int i = 0; i < 20; i++) begin
            send_a(W'(2 * (i + 3) * (i + 3)), T'(i), W'(64 * (i + 3)), 0, 0);
        end
        idle_a(1);
        drain(300);
        rnd_mode = 0;
        idle_a(2);

        send_a(16'h0800, 8'd30, 16'h0800, 0, 0);
        send_a(16'h2000, 8'd31, 16'h1000, 0, 0);
        send_a(16'h3800, 8'd32, 16'h152A, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        q_a.delete();
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_data_out", data_out, 0);
        chk("midrst_tag_out", tag_out, 0);
        chk("midrst_in_ready", in_ready, 1);
        #2 reset = 1'b0;
        send_a(16'h0400, 8'd40, 16'h05A8, 0, 1);
        idle_a(8);
        drain(50);

        vb[0] = 24'h010000; vb[1] = 24'h040000; vb[2] = 24'h008000;
        vb[3] = 24'h000000; vb[4] = 24'h00000E; vb[5] = 24'h070000;
        vb[6] = 24'h7FFFFF; vb[7] = 24'h80000E; vb[8] = 24'h88000E;
        for (int i = 0; i < 9; i++) send_b(vb[i], T2'(i));
        @(negedge clk);
        iv_b = 1'b0;
        drain(100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
